// File: rtl/compare_timer.sv
// ============================================================================
// Module   : compare_timer
// Brief    : Multi-channel compare timer (periodic / one-shot / sequence)
//            with shadow-buffered compare targets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module compare_timer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    localparam int CH_W      = $clog2(NUM_CH)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic [1:0]                   i_mode,
    input  logic [CH_W-1:0]              i_sel,
    input  logic                         i_load,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_cmp_data,
    output logic [DATA_WIDTH-1:0]        o_count,
    output logic                         o_valid,
    output logic [CH_W-1:0]              o_match_ch,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam logic [1:0]      C_MODE_ONESHOT = 2'b01;
    localparam logic [1:0]      C_MODE_SEQ     = 2'b10;
    localparam logic [CH_W-1:0] C_LAST_CH      = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_count;
    logic                  r_valid;
    logic [CH_W-1:0]       r_match_ch;
    logic [CH_W-1:0]       r_ch;
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_shadow [NUM_CH];
    logic [DATA_WIDTH-1:0] r_active [NUM_CH];

    logic                  w_match;
    logic [CH_W-1:0]       w_sel;
    logic [CH_W-1:0]       w_ch_next;

    // A match is suppressed when enable drops in the same cycle.
    assign w_match   = (r_state == S_RUN) && i_enable && (r_count == r_active[r_ch]);
    assign w_sel     = (i_sel > C_LAST_CH) ? '0 : i_sel;
    assign w_ch_next = (r_ch == C_LAST_CH) ? '0 : r_ch + 1'b1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_enable) w_state_nxt = S_RUN;
            S_RUN: begin
                if (!i_enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_match && (r_mode == C_MODE_ONESHOT)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: if (!i_enable) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_match_ch <= '0;
            r_ch       <= '0;
            r_mode     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_shadow[c] <= '0;
                r_active[c] <= '0;
            end
        end else begin
            r_valid <= w_match;
            if (w_match) begin
                r_match_ch <= r_ch;
            end
            if (i_load) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_shadow[c] <= i_cmp_data[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            case (r_state)
                S_RUN: begin
                    // Active targets only change at interval boundaries; they
                    // take the shadow value as it stood before this edge.
                    if (!i_enable || w_match) begin
                        r_count <= '0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            r_active[c] <= r_shadow[c];
                        end
                        if (w_match && (r_mode == C_MODE_SEQ)) begin
                            r_ch <= w_ch_next;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_count <= '0;
                    if (i_load) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            r_active[c] <= i_cmp_data[c*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    if ((r_state == S_IDLE) && i_enable) begin
                        r_mode <= i_mode;
                        r_ch   <= w_sel;
                    end
                end
            endcase
        end
    end

    assign o_count    = r_count;
    assign o_valid    = r_valid;
    assign o_match_ch = r_match_ch;
    assign o_busy     = (r_state == S_RUN);
    assign o_done     = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_compare_timer.sv
// ============================================================================
// Module   : tb_compare_timer
// Brief    : Directed self-checking bench for compare_timer with a match queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_compare_timer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        enable4;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic        load;
    logic        load4;
    logic [31:0] cmp;
    logic [15:0] cmp4;

    logic [7:0]  count8;
    logic        valid8;
    logic [1:0]  match_ch8;
    logic        busy8;
    logic        done8;
    logic [3:0]  count4;
    logic        valid4;
    logic [1:0]  match_ch4;
    logic        busy4;
    logic        done4;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t0;

    typedef struct {
        int         cyc;
        logic [1:0] ch;
    } exp_t;
    exp_t q[$];

    compare_timer #(.DATA_WIDTH(8), .NUM_CH(4)) u_dut8 (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_enable   (enable),
        .i_mode     (mode),
        .i_sel      (sel),
        .i_load     (load),
        .i_cmp_data (cmp),
        .o_count    (count8),
        .o_valid    (valid8),
        .o_match_ch (match_ch8),
        .o_busy     (busy8),
        .o_done     (done8)
    );

    compare_timer #(.DATA_WIDTH(4), .NUM_CH(4)) u_dut4 (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_enable   (enable4),
        .i_mode     (mode),
        .i_sel      (sel),
        .i_load     (load4),
        .i_cmp_data (cmp4),
        .o_count    (count4),
        .o_valid    (valid4),
        .o_match_ch (match_ch4),
        .o_busy     (busy4),
        .o_done     (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] pack8(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    // Every o_valid pulse of the 8-bit instance must match the queue head.
    always @(negedge clk) begin
        if (valid8 === 1'b1) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_valid observed=1 expected=0 (cycle %0d)", cyc);
            end
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("match_cycle", cyc, e.cyc);
                check("match_ch", {30'd0, match_ch8}, {30'd0, e.ch});
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; enable4 = 1'b0; mode = 2'd0; sel = 2'd0;
        load = 1'b0; load4 = 1'b0; cmp = '0; cmp4 = '0;
        step(2);
        check("rst_count", count8, 0);
        check("rst_valid", valid8, 0);
        check("rst_match_ch", match_ch8, 0);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_count4", count4, 0);
        reset = 1'b0;
        step(1);

        // Periodic, target 3
        cmp = pack8(3, 0, 0, 0); load = 1'b1; step(1); load = 1'b0;
        mode = 2'd0; sel = 2'd0; enable = 1'b1; t0 = cyc + 1;
        q.push_back('{t0 + 4, 2'd0});
        q.push_back('{t0 + 8, 2'd0});
        q.push_back('{t0 + 12, 2'd0});
        step(1);
        check("per_busy", busy8, 1);
        check("per_count0", count8, 0);
        for (int i = 1; i <= 3; i++) begin
            step(1);
            check("per_count", count8, i);
        end
        step(1);
        check("per_wrap", count8, 0);
        step(8);
        enable = 1'b0;
        step(1);
        check("per_stop_busy", busy8, 0);
        check("per_stop_count", count8, 0);

        // One-shot, target 5
        cmp = pack8(5, 0, 0, 0); load = 1'b1; step(1); load = 1'b0;
        mode = 2'd1; enable = 1'b1; t0 = cyc + 1;
        q.push_back('{t0 + 6, 2'd0});
        step(4);
        check("os_count3", count8, 3);
        step(3);
        check("os_done", done8, 1);
        check("os_busy", busy8, 0);
        check("os_count", count8, 0);
        step(1);
        check("os_hold_done", done8, 1);
        enable = 1'b0;
        step(1);
        check("os_idle_done", done8, 0);
        check("os_idle_busy", busy8, 0);

        // Sequence, targets {1,2,0,3}; mode/sel changes mid-run must be ignored
        cmp = pack8(1, 2, 0, 3); load = 1'b1; step(1); load = 1'b0;
        mode = 2'd2; sel = 2'd0; enable = 1'b1; t0 = cyc + 1;
        q.push_back('{t0 + 2, 2'd0});
        q.push_back('{t0 + 5, 2'd1});
        q.push_back('{t0 + 6, 2'd2});
        q.push_back('{t0 + 10, 2'd3});
        q.push_back('{t0 + 12, 2'd0});
        step(2);
        mode = 2'd0; sel = 2'd2;
        step(11);
        enable = 1'b0;
        step(1);
        check("seq_stop_busy", busy8, 0);

        // Load during RUN, including a load on a match edge
        mode = 2'd0; sel = 2'd0;
        cmp = pack8(7, 0, 0, 0); load = 1'b1; step(1); load = 1'b0;
        enable = 1'b1; t0 = cyc + 1;
        q.push_back('{t0 + 8, 2'd0});
        q.push_back('{t0 + 11, 2'd0});
        q.push_back('{t0 + 14, 2'd0});
        q.push_back('{t0 + 16, 2'd0});
        step(5);
        check("lr_count4", count8, 4);
        cmp = pack8(2, 0, 0, 0); load = 1'b1; step(1); load = 1'b0;
        step(2);
        check("lr_count7", count8, 7);
        step(3);
        check("lr_count2", count8, 2);
        cmp = pack8(1, 0, 0, 0); load = 1'b1; step(1); load = 1'b0;
        step(5);
        enable = 1'b0;
        step(1);

        // Asynchronous reset mid-run
        cmp = pack8(7, 0, 0, 0); load = 1'b1; step(1); load = 1'b0;
        enable = 1'b1; t0 = cyc + 1;
        step(4);
        check("ar_count3", count8, 3);
        #2 reset = 1'b1;
        #1;
        check("ar_count", count8, 0);
        check("ar_busy", busy8, 0);
        check("ar_valid", valid8, 0);
        enable = 1'b0;
        step(1);
        reset = 1'b0;
        step(1);
        check("ar_after_busy", busy8, 0);
        check("ar_after_count", count8, 0);

        // Enable drop on a match cycle suppresses o_valid
        cmp = pack8(2, 0, 0, 0); load = 1'b1; step(1); load = 1'b0;
        enable = 1'b1; t0 = cyc + 1;
        step(3);
        check("ed_count2", count8, 2);
        enable = 1'b0;
        step(1);
        check("ed_valid", valid8, 0);
        check("ed_busy", busy8, 0);
        check("ed_count", count8, 0);

        // 4-bit boundary: target 15 then target 0
        cmp4 = 16'h000F; load4 = 1'b1; step(1); load4 = 1'b0;
        enable4 = 1'b1;
        step(16);
        check("b15_count", count4, 15);
        check("b15_valid_pre", valid4, 0);
        step(1);
        check("b15_valid", valid4, 1);
        check("b15_count0", count4, 0);
        enable4 = 1'b0;
        step(1);
        cmp4 = 16'h0000; load4 = 1'b1; step(1); load4 = 1'b0;
        enable4 = 1'b1;
        step(2);
        check("b0_valid_a", valid4, 1);
        step(1);
        check("b0_valid_b", valid4, 1);
        step(1);
        check("b0_valid_c", valid4, 1);
        check("b0_count", count4, 0);
        enable4 = 1'b0;
        step(1);
        check("b0_valid_off", valid4, 0);

        step(2);
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/compare_timer.md
COMPARE_TIMER -- requirements
Module: compare_timer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the counter and compare-value width.
REQ-002 Parameter NUM_CH, default 4, minimum 2, SHALL set the number of compare channels; CH_W = clog2(NUM_CH).
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 i_enable  input  1  SHALL start the timer when high and stop it when low.
REQ-006 i_mode  input  2  SHALL select the mode: 00 periodic, 01 one-shot, 10 sequence, 11 treated as 00.
REQ-007 i_sel  input  CH_W  SHALL select the start channel; values >= NUM_CH map to channel 0.
REQ-008 i_load  input  1  SHALL be a one-cycle pulse that writes i_cmp_data into the shadow compare registers.
REQ-009 i_cmp_data  input  NUM_CH*DATA_WIDTH  SHALL carry the compare values; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-010 o_count  output  DATA_WIDTH  SHALL carry the current counter value.
REQ-011 o_valid  output  1  SHALL be a registered one-cycle match pulse.
REQ-012 o_match_ch  output  CH_W  SHALL give the channel that produced the current o_valid.
REQ-013 o_busy  output  1  SHALL be high in state RUN.
REQ-014 o_done  output  1  SHALL be high in state DONE.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE, o_count SHALL be 0 and i_enable=1 SHALL move the FSM to RUN.
REQ-017 On the IDLE->RUN transition, i_mode and i_sel SHALL be latched; changes during RUN have no effect.
REQ-018 Each RUN cycle with o_count != target[ch] SHALL set o_count to o_count+1.
REQ-019 Each RUN cycle with o_count == target[ch] SHALL, on the next edge, set o_count to 0, o_valid to 1 and o_match_ch to ch.
REQ-020 The match period SHALL therefore be target+1 cycles.
REQ-021 Target 0 SHALL give an o_valid that is high every RUN cycle.
REQ-022 Target 2^DATA_WIDTH-1 SHALL be reached with no overflow wrap before the match.
REQ-023 Periodic mode SHALL stay in RUN after a match, with ch unchanged.
REQ-024 One-shot mode SHALL move to DONE on a match, with o_count 0 and o_valid pulsed once.
REQ-025 Sequence mode SHALL advance ch on each match: ch+1, wrapping from NUM_CH-1 to 0; the next interval uses the new channel's target.
REQ-026 DONE SHALL hold until i_enable is low, then move to IDLE.
REQ-027 i_enable low in RUN SHALL move the FSM to IDLE and clear o_count; no o_valid is issued that edge, even if a match coincides.
REQ-028 i_load in IDLE or DONE SHALL update the active targets on the next edge.
REQ-029 i_load in RUN SHALL update only the shadow registers; shadow values SHALL be copied to the active targets on the next match edge or on RUN exit.
REQ-030 i_load coinciding with a match edge SHALL still be captured, and SHALL become active at the following match.
REQ-031 o_valid SHALL be 0 in every cycle not covered by REQ-019.

Reset
REQ-032 While i_reset is high, the FSM SHALL be in IDLE with o_count=0, o_valid=0, o_match_ch=0, o_busy=0, o_done=0, and all shadow and active targets 0.
REQ-033 Reset asserted mid-RUN SHALL take effect immediately, asynchronously, and discard any pending shadow update.
REQ-034 After reset deasserts, operation SHALL resume only through the IDLE->RUN entry of REQ-016.

Verification
REQ-035 Periodic test: DATA_WIDTH=8, ch0 target 3, mode 00, enable held -> o_valid on cycles 4, 8, 12 after RUN entry, o_count sequence 0,1,2,3,0.
REQ-036 One-shot test: target 5, mode 01 -> single o_valid, then o_done=1 and o_count=0; de-asserting enable -> IDLE.
REQ-037 Sequence test: targets {1,2,0,3}, mode 10, sel 0 -> o_match_ch 0,1,2,3,0 at intervals 2,3,1,4 cycles.
REQ-038 Load-in-RUN test: target 7, load 2 at count 4 -> match at 7, then the next match at count 2.
REQ-039 Boundary test: DATA_WIDTH=4, target 15 -> match after 16 cycles with no wrap; target 0 -> o_valid continuous.
REQ-040 Reset test: reset asserted at count 3 mid-RUN -> all outputs 0 immediately; enable drop coinciding with a match -> no o_valid.
